// File: rtl/whack_judge_pkg.sv
// Shared definitions for the whack-a-mole game blocks: state codes, hole geometry,
// and the two-digit BCD score helpers.
package whack_judge_pkg;

    localparam int unsigned POS_W     = 3;
    localparam int unsigned NUM_HOLES = 5;
    localparam int unsigned NO_MOLE   = 5;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned LIVES_W   = 2;
    localparam int unsigned DIGIT_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ARMED = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd2_t;

    // One-hot hole mask for a valid mole position.
    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [POS_W-1:0] pos);
        logic [NUM_HOLES-1:0] one;
        one = NUM_HOLES'(1);
        return one << pos;
    endfunction

    // Two-digit BCD increment; callers guarantee the value is below the saturation point.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        if (v.ones == DIGIT_W'(9)) begin
            r.ones = '0;
            r.tens = v.tens + DIGIT_W'(1);
        end else begin
            r.ones = v.ones + DIGIT_W'(1);
            r.tens = v.tens;
        end
        return r;
    endfunction

endpackage

// File: rtl/whack_judge_edge_detect.sv
// Rising-edge detector: one registered copy of the input and a combinational rise mask.
module edge_detect #(
    parameter int unsigned W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_level,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    always_comb begin
        prev_d = i_level;
        rise_c = i_level & ~prev_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/whack_judge.sv
// Game-rule stage: judges button presses against the mole position, keeps the BCD
// score and lives, and requests new mole positions from the placer.
module whack_judge
    import whack_judge_pkg::*;
#(
    parameter int unsigned LIVES     = 3,
    parameter int unsigned SCORE_MAX = 99
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NUM_HOLES-1:0] i_buttons,
    input  logic [POS_W-1:0]     i_mole_position,
    input  logic                 i_position_changed,
    output logic                 o_change_position,
    output logic                 o_hit,
    output logic                 o_miss,
    output logic [DIGIT_W-1:0]   o_score_tens,
    output logic [DIGIT_W-1:0]   o_score_ones,
    output logic [LIVES_W-1:0]   o_lives,
    output logic [STATE_W-1:0]   o_state
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [DIGIT_W-1:0] MAX_TENS   = DIGIT_W'(SCORE_MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_ONES   = DIGIT_W'(SCORE_MAX % 10);

    state_e               state_q, state_d;
    bcd2_t                score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic                 chg_q, chg_d;

    logic [NUM_HOLES-1:0] press_c;
    logic [0:0]           start_rise_c;

    edge_detect #(.W(NUM_HOLES)) u_btn_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (i_buttons),
        .rise_c  (press_c)
    );

    edge_detect #(.W(1)) u_start_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (i_start),
        .rise_c  (start_rise_c)
    );

    // Judging events for this cycle, in the ARMED priority order.
    logic armed_c, mole_valid_c, game_start_c;
    logic escape_c, hit_ev_c, wrong_ev_c, lose_ev_c, last_life_c, score_max_c;

    always_comb begin
        armed_c      = (state_q == ST_ARMED);
        mole_valid_c = (i_mole_position < POS_W'(NO_MOLE));
        game_start_c = start_rise_c[0] && (state_q == ST_IDLE || state_q == ST_OVER);
        escape_c     = armed_c && i_position_changed;
        hit_ev_c     = armed_c && !i_position_changed && mole_valid_c
                       && (press_c == hole_onehot(i_mole_position));
        wrong_ev_c   = armed_c && !i_position_changed && mole_valid_c
                       && (press_c != '0) && !hit_ev_c;
        lose_ev_c    = escape_c || wrong_ev_c;
        last_life_c  = (lives_q <= LIVES_W'(1));
        score_max_c  = (score_q.tens == MAX_TENS) && (score_q.ones == MAX_ONES);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (game_start_c) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_position_changed) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (lose_ev_c && last_life_c) begin
                    state_d = ST_OVER;
                end else if (hit_ev_c) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses, score and lives; all registered one cycle after the judged event.
    always_comb begin
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        chg_d   = 1'b0;
        score_d = score_q;
        lives_d = lives_q;
        if (game_start_c) begin
            chg_d   = 1'b1;
            score_d = '0;
            lives_d = LIVES_INIT;
        end else if (hit_ev_c) begin
            hit_d = 1'b1;
            chg_d = 1'b1;
            if (!score_max_c) score_d = bcd_inc(score_q);
        end else if (lose_ev_c) begin
            miss_d  = 1'b1;
            lives_d = last_life_c ? '0 : lives_q - LIVES_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            chg_q   <= 1'b0;
            score_q <= '0;
            lives_q <= LIVES_INIT;
        end else begin
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            chg_q   <= chg_d;
            score_q <= score_d;
            lives_q <= lives_d;
        end
    end

    always_comb begin
        o_hit             = hit_q;
        o_miss            = miss_q;
        o_change_position = chg_q;
        o_score_tens      = score_q.tens;
        o_score_ones      = score_q.ones;
        o_lives           = lives_q;
        o_state           = state_q;
    end

endmodule

// File: tb/tb_whack_judge.sv
// Self-checking bench for whack_judge: vector table, hit/saturation loop, async reset.
module tb_whack_judge;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] buttons;
    logic [2:0] mole;
    logic       pchg;
    logic       o_change_position, o_hit, o_miss;
    logic [3:0] o_score_tens, o_score_ones;
    logic [1:0] o_lives, o_state;

    always #5 clk = ~clk;

    whack_judge #(.LIVES(3), .SCORE_MAX(99)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_buttons          (buttons),
        .i_mole_position    (mole),
        .i_position_changed (pchg),
        .o_change_position  (o_change_position),
        .o_hit              (o_hit),
        .o_miss             (o_miss),
        .o_score_tens       (o_score_tens),
        .o_score_ones       (o_score_ones),
        .o_lives            (o_lives),
        .o_state            (o_state)
    );

    typedef struct packed {
        logic       hit;
        logic       miss;
        logic       chg;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [1:0] lives;
        logic [1:0] state;
    } out_t;

    typedef struct {
        string      name;
        logic       start;
        logic [4:0] bt;
        logic [2:0] mp;
        logic       pc;
        out_t       exp;
    } vec_t;

    out_t sb_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   sc = 0;

    function automatic out_t e(logic h, logic m, logic c, int tens, int ones, int lives, int st);
        out_t r;
        r.hit = h; r.miss = m; r.chg = c;
        r.tens = 4'(tens); r.ones = 4'(ones);
        r.lives = 2'(lives); r.state = 2'(st);
        return r;
    endfunction

    function automatic vec_t v(string n, logic s, logic [4:0] b, logic [2:0] m, logic p, out_t x);
        vec_t r;
        r.name = n; r.start = s; r.bt = b; r.mp = m; r.pc = p; r.exp = x;
        return r;
    endfunction

    task automatic check(input string name, input out_t x);
        out_t a;
        a = {o_hit, o_miss, o_change_position, o_score_tens, o_score_ones, o_lives, o_state};
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got hit=%0b miss=%0b chg=%0b score=%0d%0d lives=%0d state=%0d, want hit=%0b miss=%0b chg=%0b score=%0d%0d lives=%0d state=%0d",
                     name, a.hit, a.miss, a.chg, a.tens, a.ones, a.lives, a.state,
                     x.hit, x.miss, x.chg, x.tens, x.ones, x.lives, x.state);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, compare after the edge.
    task automatic apply(input vec_t x);
        out_t got_exp;
        @(negedge clk);
        start = x.start; buttons = x.bt; mole = x.mp; pchg = x.pc;
        sb_q.push_back(x.exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty, want 1 entry", x.name);
        end else begin
            got_exp = sb_q.pop_front();
            check(x.name, got_exp);
        end
    endtask

    // One full hit round: strobe into ARMED, press the mole's hole, release.
    task automatic hit_round(input int k, input int lives);
        logic [4:0] oh;
        int prev;
        prev = sc;
        oh = 5'(1) << k;
        apply(v("hr_arm", 1'b0, 5'b0, 3'(k), 1'b1, e(0, 0, 0, prev / 10, prev % 10, lives, 2)));
        if (sc < 99) sc = sc + 1;
        apply(v("hr_hit", 1'b0, oh, 3'(k), 1'b0, e(1, 0, 1, sc / 10, sc % 10, lives, 1)));
        apply(v("hr_rel", 1'b0, 5'b0, 3'(k), 1'b0, e(0, 0, 0, sc / 10, sc % 10, lives, 1)));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; buttons = 5'b0; mole = 3'd7; pchg = 1'b0;

        tbl.push_back(v("idle",         0, 5'b00000, 3'd7, 0, e(0,0,0, 0,0, 3,0)));
        tbl.push_back(v("start",        1, 5'b00000, 3'd7, 0, e(0,0,1, 0,0, 3,1)));
        tbl.push_back(v("start_held",   1, 5'b00000, 3'd7, 0, e(0,0,0, 0,0, 3,1)));
        tbl.push_back(v("arm",          0, 5'b00000, 3'd2, 1, e(0,0,0, 0,0, 3,2)));
        tbl.push_back(v("hit_m2",       0, 5'b00100, 3'd2, 0, e(1,0,1, 0,1, 3,1)));
        tbl.push_back(v("held_wait",    0, 5'b00100, 3'd2, 0, e(0,0,0, 0,1, 3,1)));
        tbl.push_back(v("rearm_held",   0, 5'b00100, 3'd2, 1, e(0,0,0, 0,1, 3,2)));
        tbl.push_back(v("held_no_hit",  0, 5'b00100, 3'd2, 0, e(0,0,0, 0,1, 3,2)));
        tbl.push_back(v("rel_m3",       0, 5'b00000, 3'd3, 0, e(0,0,0, 0,1, 3,2)));
        tbl.push_back(v("wrong_b0",     0, 5'b00001, 3'd3, 0, e(0,1,0, 0,1, 2,2)));
        tbl.push_back(v("rel1",         0, 5'b00000, 3'd3, 0, e(0,0,0, 0,1, 2,2)));
        tbl.push_back(v("multi_b13",    0, 5'b01010, 3'd3, 0, e(0,1,0, 0,1, 1,2)));
        tbl.push_back(v("rel2",         0, 5'b00000, 3'd3, 0, e(0,0,0, 0,1, 1,2)));
        tbl.push_back(v("third_miss",   0, 5'b00001, 3'd3, 0, e(0,1,0, 0,1, 0,3)));
        tbl.push_back(v("over_rel",     0, 5'b00000, 3'd3, 0, e(0,0,0, 0,1, 0,3)));
        tbl.push_back(v("over_press",   0, 5'b01000, 3'd3, 0, e(0,0,0, 0,1, 0,3)));
        tbl.push_back(v("over_idle",    0, 5'b00000, 3'd3, 0, e(0,0,0, 0,1, 0,3)));
        tbl.push_back(v("restart",      1, 5'b00000, 3'd3, 0, e(0,0,1, 0,0, 3,1)));
        tbl.push_back(v("arm_m4",       0, 5'b00000, 3'd4, 1, e(0,0,0, 0,0, 3,2)));
        tbl.push_back(v("nomole_press", 0, 5'b00010, 3'd6, 0, e(0,0,0, 0,0, 3,2)));
        tbl.push_back(v("nomole_rel",   0, 5'b00000, 3'd4, 0, e(0,0,0, 0,0, 3,2)));
        tbl.push_back(v("escape1",      0, 5'b00000, 3'd1, 1, e(0,1,0, 0,0, 2,2)));
        tbl.push_back(v("escape_hitbtn",0, 5'b00001, 3'd0, 1, e(0,1,0, 0,0, 1,2)));
        tbl.push_back(v("esc_rel",      0, 5'b00000, 3'd0, 0, e(0,0,0, 0,0, 1,2)));
        tbl.push_back(v("escape3",      0, 5'b00000, 3'd2, 1, e(0,1,0, 0,0, 0,3)));
        tbl.push_back(v("over_stay",    0, 5'b00000, 3'd2, 0, e(0,0,0, 0,0, 0,3)));

        repeat (2) @(posedge clk);
        #1;
        check("in_reset", e(0,0,0, 0,0, 3,0));
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // From OVER: start, then 100 hits covering the 09->10 rollover and saturation at 99.
        apply(v("start_100", 1, 5'b0, 3'd7, 0, e(0,0,1, 0,0, 3,1)));
        start = 1'b0;
        sc = 0;
        for (int i = 1; i <= 100; i++) hit_round(i % 5, 3);

        // Fresh game to score 05, then reset asynchronously while ARMED.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_between", e(0,0,0, 0,0, 3,0));
        @(negedge clk);
        rst = 1'b0;
        apply(v("start_b", 1, 5'b0, 3'd7, 0, e(0,0,1, 0,0, 3,1)));
        sc = 0;
        for (int i = 0; i < 5; i++) hit_round(i, 3);
        apply(v("arm_05", 0, 5'b0, 3'd1, 1, e(0,0,0, 0,5, 3,2)));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", e(0,0,0, 0,0, 3,0));
        @(negedge clk);
        rst = 1'b0;
        apply(v("post_rst", 0, 5'b0, 3'd7, 0, e(0,0,0, 0,0, 3,0)));

        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
